// File: rtl/workspace_logic_pkg.sv
// rtl/workspace_logic_pkg.sv - op codes and width helper for the registered bitwise unit
package workspace_logic_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_ANDN  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASSA = 3'd7;

  // Width needed to hold a population count of 0..w.
  function automatic int ones_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/workspace_logic_if.sv
// rtl/workspace_logic_if.sv - valid/ready operand and result bundle for workspace_logic_pipe
interface workspace_logic_if #(
  parameter int W = 8
) ();
  import workspace_logic_pkg::*;

  localparam int CW = ones_width(W);

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [OP_W-1:0] op;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    res;
  logic [CW-1:0]   ones;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, res, ones
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, res, ones
  );

endinterface

// File: rtl/workspace_logic_core.sv
// rtl/workspace_logic_core.sv - combinational bitwise op select plus population count
module workspace_logic_core
  import workspace_logic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]               a,
  input  logic [W-1:0]               b,
  input  logic [OP_W-1:0]            op,
  output logic [W-1:0]               res,
  output logic [ones_width(W)-1:0]   ones
);

  localparam int CW = ones_width(W);

  always_comb begin
    res = '0;
    case (op)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NAND:  res = ~(a & b);
      OP_NOR:   res = ~(a | b);
      OP_XNOR:  res = ~(a ^ b);
      OP_ANDN:  res = a & ~b;
      OP_PASSA: res = a;
      default:  res = '0;
    endcase
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + CW'(res[i]);
    end
  end

endmodule

// File: rtl/workspace_logic_pipe.sv
// rtl/workspace_logic_pipe.sv - STAGES-deep valid/ready pipeline around workspace_logic_core
module workspace_logic_pipe
  import workspace_logic_pkg::*;
#(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  workspace_logic_if.slave bus
);

  localparam int CW = ones_width(W);

  logic [W-1:0]      core_res;
  logic [CW-1:0]     core_ones;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] en;
  logic [W-1:0]      res_s  [STAGES];
  logic [CW-1:0]     ones_s [STAGES];

  workspace_logic_core #(.W(W)) u_core (
    .a    (bus.a),
    .b    (bus.b),
    .op   (bus.op),
    .res  (core_res),
    .ones (core_ones)
  );

  // A stage may load when it is empty or its content moves on; this lets bubbles collapse.
  always_comb begin
    en = '0;
    en[STAGES-1] = !v[STAGES-1] || bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      en[k] = !v[k] || en[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          src_v;
    logic [W-1:0]  src_res;
    logic [CW-1:0] src_ones;
    logic          v_q;
    logic [W-1:0]  res_q;
    logic [CW-1:0] ones_q;

    if (k == 0) begin : g_head
      assign src_v    = bus.in_valid;
      assign src_res  = core_res;
      assign src_ones = core_ones;
    end else begin : g_body
      assign src_v    = v[k-1];
      assign src_res  = res_s[k-1];
      assign src_ones = ones_s[k-1];
    end

    // Data only moves with a valid source, so the visible result never changes under a bubble.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q    <= 1'b0;
        res_q  <= '0;
        ones_q <= '0;
      end else if (en[k]) begin
        v_q <= src_v;
        if (src_v) begin
          res_q  <= src_res;
          ones_q <= src_ones;
        end
      end
    end

    assign v[k]      = v_q;
    assign res_s[k]  = res_q;
    assign ones_s[k] = ones_q;
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = v[STAGES-1];
  assign bus.res       = res_s[STAGES-1];
  assign bus.ones      = ones_s[STAGES-1];

endmodule

// File: tb/tb_workspace_logic_pipe.sv
// tb/tb_workspace_logic_pipe.sv - directed and random checks for workspace_logic_pipe
module tb_workspace_logic_pipe;
  import workspace_logic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  workspace_logic_if #(.W(8))  bus8 ();
  workspace_logic_if #(.W(1))  bus1 ();
  workspace_logic_if #(.W(16)) bus16 ();

  workspace_logic_pipe #(.W(8),  .STAGES(2)) u8  (.clk(clk), .rst(rst), .bus(bus8));
  workspace_logic_pipe #(.W(1),  .STAGES(1)) u1  (.clk(clk), .rst(rst), .bus(bus1));
  workspace_logic_pipe #(.W(16), .STAGES(3)) u16 (.clk(clk), .rst(rst), .bus(bus16));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return x & ~y;
      default: return x;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    sample();
    n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus8.out_valid); end
    n_cmp++; if (bus8.res !== 8'h00) begin n_bad++; $display("FAIL reset_res: got %h want 00", bus8.res); end
    n_cmp++; if (bus8.ones !== 4'd0) begin n_bad++; $display("FAIL reset_ones: got %0d want 0", bus8.ones); end
    n_cmp++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus8.in_ready); end
  endtask

  task automatic test_reset_mid();
    step();
    bus8.out_ready = 1'b0;
    bus8.in_valid = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.op = OP_AND;
    step();
    step();
    bus8.in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    sample();
    n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out_valid: got %b want 0", bus8.out_valid); end
    n_cmp++; if (bus8.res !== 8'h00) begin n_bad++; $display("FAIL rst_mid_res: got %h want 00", bus8.res); end
    n_cmp++; if (bus8.ones !== 4'd0) begin n_bad++; $display("FAIL rst_mid_ones: got %0d want 0", bus8.ones); end
    n_cmp++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready: got %b want 1", bus8.in_ready); end
    bus8.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      sample();
      n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_emit: cycle %0d got %b want 0", c, bus8.out_valid); end
    end
  endtask

  task automatic test_op_sweep();
    logic [7:0] sw_res  [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};
    logic [3:0] sw_ones [8] = '{4'd2, 4'd6, 4'd4, 4'd6, 4'd2, 4'd4, 4'd2, 4'd4};
    logic exp_v;
    bus8.out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step();
      if (n < 8) begin
        bus8.in_valid = 1'b1; bus8.a = 8'hF0; bus8.b = 8'h3C; bus8.op = 3'(n);
      end else begin
        bus8.in_valid = 1'b0;
      end
      sample();
      if (n < 8) begin
        n_cmp++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL sweep_in_ready: cycle %0d got %b want 1", n, bus8.in_ready); end
      end
      exp_v = (n >= 2) && (n < 10);
      n_cmp++; if (bus8.out_valid !== exp_v) begin n_bad++; $display("FAIL sweep_out_valid: cycle %0d got %b want %b", n, bus8.out_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (bus8.res !== sw_res[n-2]) begin n_bad++; $display("FAIL sweep_res: op %0d got %h want %h", n - 2, bus8.res, sw_res[n-2]); end
        n_cmp++; if (bus8.ones !== sw_ones[n-2]) begin n_bad++; $display("FAIL sweep_ones: op %0d got %0d want %0d", n - 2, bus8.ones, sw_ones[n-2]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bp_a  [3] = '{8'hAA, 8'h55, 8'h81};
    logic [7:0] bp_b  [3] = '{8'h0F, 8'h0F, 8'h7E};
    logic [2:0] bp_op [3] = '{OP_AND, OP_OR, OP_XOR};
    int acc = 0;
    step();
    bus8.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus8.in_valid = 1'b1; bus8.a = bp_a[acc]; bus8.b = bp_b[acc]; bus8.op = bp_op[acc];
      sample();
      if (!bus8.in_ready) break;
      acc++;
      step();
    end
    n_cmp++; if (acc !== 2) begin n_bad++; $display("FAIL bp_accept_count: got %0d want 2", acc); end
    step();
    bus8.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      n_cmp++; if (bus8.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_in_ready: got %b want 0", bus8.in_ready); end
      n_cmp++; if (bus8.out_valid !== 1'b1 || bus8.res !== 8'h0A || bus8.ones !== 4'd2)
        begin n_bad++; $display("FAIL bp_hold: got v=%b res=%h ones=%0d want v=1 res=0a ones=2", bus8.out_valid, bus8.res, bus8.ones); end
      step();
    end
    bus8.out_ready = 1'b1;
    sample();
    n_cmp++; if (bus8.out_valid !== 1'b1 || bus8.res !== 8'h0A) begin n_bad++; $display("FAIL bp_drain0: got v=%b res=%h want v=1 res=0a", bus8.out_valid, bus8.res); end
    step();
    sample();
    n_cmp++; if (bus8.out_valid !== 1'b1 || bus8.res !== 8'h5F || bus8.ones !== 4'd6)
      begin n_bad++; $display("FAIL bp_drain1: got v=%b res=%h ones=%0d want v=1 res=5f ones=6", bus8.out_valid, bus8.res, bus8.ones); end
    step();
    sample();
    n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain_end: got %b want 0", bus8.out_valid); end
  endtask

  task automatic test_simultaneous();
    step();
    bus8.out_ready = 1'b0;
    bus8.in_valid = 1'b1; bus8.a = 8'h0F; bus8.b = 8'hFF; bus8.op = OP_AND;
    step();
    bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.op = OP_NOR;
    step();
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.op = OP_XOR;
    bus8.out_ready = 1'b1;
    sample();
    n_cmp++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL sim_in_ready: got %b want 1", bus8.in_ready); end
    n_cmp++; if (bus8.out_valid !== 1'b1 || bus8.res !== 8'h0F || bus8.ones !== 4'd4)
      begin n_bad++; $display("FAIL sim_out: got v=%b res=%h ones=%0d want v=1 res=0f ones=4", bus8.out_valid, bus8.res, bus8.ones); end
    step();
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b0;
    sample();
    n_cmp++; if (bus8.out_valid !== 1'b1 || bus8.res !== 8'h00 || bus8.ones !== 4'd0)
      begin n_bad++; $display("FAIL sim_next: got v=%b res=%h ones=%0d want v=1 res=00 ones=0", bus8.out_valid, bus8.res, bus8.ones); end
    n_cmp++; if (bus8.in_ready !== 1'b0) begin n_bad++; $display("FAIL sim_still_full: got %b want 0", bus8.in_ready); end
    step();
    bus8.out_ready = 1'b1;
    step();
    sample();
    n_cmp++; if (bus8.out_valid !== 1'b1 || bus8.res !== 8'h26 || bus8.ones !== 4'd3)
      begin n_bad++; $display("FAIL sim_last: got v=%b res=%h ones=%0d want v=1 res=26 ones=3", bus8.out_valid, bus8.res, bus8.ones); end
    step();
    sample();
    n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL sim_empty: got %b want 0", bus8.out_valid); end
  endtask

  task automatic test_widths();
    int lat = 0;
    step();
    bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.op = OP_XOR; bus1.out_ready = 1'b1;
    sample();
    n_cmp++; if (bus1.in_ready !== 1'b1) begin n_bad++; $display("FAIL w1_in_ready: got %b want 1", bus1.in_ready); end
    step();
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.op = OP_OR;
    sample();
    n_cmp++; if (bus1.out_valid !== 1'b1 || bus1.res !== 1'b0 || bus1.ones !== 1'b0)
      begin n_bad++; $display("FAIL w1_xor: got v=%b res=%b ones=%0d want v=1 res=0 ones=0", bus1.out_valid, bus1.res, bus1.ones); end
    step();
    bus1.in_valid = 1'b0;
    sample();
    n_cmp++; if (bus1.out_valid !== 1'b1 || bus1.res !== 1'b1 || bus1.ones !== 1'b1)
      begin n_bad++; $display("FAIL w1_or: got v=%b res=%b ones=%0d want v=1 res=1 ones=1", bus1.out_valid, bus1.res, bus1.ones); end
    step();
    sample();
    n_cmp++; if (bus1.out_valid !== 1'b0) begin n_bad++; $display("FAIL w1_empty: got %b want 0", bus1.out_valid); end

    step();
    bus16.in_valid = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'h0000; bus16.op = OP_OR; bus16.out_ready = 1'b1;
    sample();
    for (int c = 1; c <= 8; c++) begin
      step();
      bus16.in_valid = 1'b0;
      sample();
      if (bus16.out_valid) begin lat = c; break; end
    end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL w16_latency: got %0d want 3", lat); end
    n_cmp++; if (bus16.res !== 16'hFFFF || bus16.ones !== 5'd16)
      begin n_bad++; $display("FAIL w16_or: got res=%h ones=%0d want res=ffff ones=16", bus16.res, bus16.ones); end
  endtask

  task automatic test_random();
    logic [11:0] q[$];
    logic [11:0] got;
    logic        acc_prev = 1'b1;
    logic        stall_prev = 1'b0;
    logic [11:0] last = '0;
    int          xfers = 0;
    int          cyc = 0;
    while (xfers < 10000 && cyc < 60000) begin
      step();
      cyc++;
      if (!bus8.in_valid || acc_prev) begin
        bus8.in_valid = ($urandom_range(0, 3) != 0);
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        bus8.op = 3'($urandom);
      end
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      sample();
      got = {bus8.res, bus8.ones};
      if (stall_prev) begin
        n_cmp++; if (bus8.out_valid !== 1'b1 || got !== last)
          begin n_bad++; $display("FAIL rnd_stall_hold: got v=%b data=%h want v=1 data=%h", bus8.out_valid, got, last); end
      end
      acc_prev = bus8.in_valid && bus8.in_ready;
      if (acc_prev) q.push_back({ref_op(bus8.a, bus8.b, bus8.op), 4'($countones(ref_op(bus8.a, bus8.b, bus8.op)))});
      if (bus8.out_valid && bus8.out_ready) begin
        xfers++;
        n_cmp++;
        if (q.size() == 0) begin n_bad++; $display("FAIL rnd_spurious: got data=%h want no output", got); end
        else if (got !== q[0]) begin n_bad++; $display("FAIL rnd_data: xfer %0d got %h want %h", xfers, got, q[0]); void'(q.pop_front()); end
        else void'(q.pop_front());
      end
      stall_prev = bus8.out_valid && !bus8.out_ready;
      last = got;
    end
    n_cmp++; if (xfers < 10000) begin n_bad++; $display("FAIL rnd_timeout: got %0d transfers want 10000", xfers); end
    step();
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (bus8.out_valid && q.size() != 0) begin
        n_cmp++; if ({bus8.res, bus8.ones} !== q[0]) begin n_bad++; $display("FAIL rnd_drain: got %h want %h", {bus8.res, bus8.ones}, q[0]); end
        void'(q.pop_front());
      end
      step();
    end
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rnd_leftover: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.op = '0;  bus8.out_ready = 1'b1;
    bus1.in_valid = 1'b0;  bus1.a = '0;  bus1.b = '0;  bus1.op = '0;  bus1.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.op = '0; bus16.out_ready = 1'b1;
    test_reset();
    test_op_sweep();
    test_backpressure();
    test_simultaneous();
    test_widths();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
